// File: rtl/pwm_capture.sv
// PWM capture: measures high time and period of pwm_i in prescaled ticks.
// Optional timeout detection is built when PWM_CAPTURE_TIMEOUT_EN is defined.
module pwm_capture #(
  parameter int CNT_W = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        write,
  input  logic [7:0]  addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  input  logic        pwm_i,
  output logic        irq_o
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] ARM     = 3'd1;
  localparam logic [2:0] HIGH_PH = 3'd2;
  localparam logic [2:0] LOW_PH  = 3'd3;
  localparam logic [2:0] DONE    = 3'd4;

  logic             ctrl_en, ctrl_irq, ctrl_os;
  logic [CNT_W-1:0] prescale, psc_act, pcnt;
  logic             sync1, sync2, hist;
  logic             rise, fall, tick;
  logic [2:0]       state;
  logic [CNT_W-1:0] cnt, cnt_inc, shadow, high_q, period_q;
  logic             valid, overflow, tmo_flag;
  logic             wr_ctrl, wr_psc, wr_stat, dis_wr;
  logic             counting, ovf_evt, cap_evt, to_evt;
  logic             unused_wdata;

  assign wr_ctrl  = write && (addr_i == 8'h00);
  assign wr_psc   = write && (addr_i == 8'h04);
  assign wr_stat  = write && (addr_i == 8'h10);
  assign dis_wr   = wr_ctrl && !wdata_i[0];
  assign unused_wdata = ^wdata_i;

  assign rise     = sync2 && !hist;
  assign fall     = !sync2 && hist;
  assign tick     = (pcnt == psc_act);

  assign cnt_inc  = (tick && !(&cnt)) ? cnt + CNT_W'(1) : cnt;
  assign counting = (state == HIGH_PH) || (state == LOW_PH);
  assign ovf_evt  = counting && tick && (&cnt) && !dis_wr;
  assign cap_evt  = (state == LOW_PH) && rise && !dis_wr;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      hist  <= 1'b0;
    end else begin
      sync1 <= pwm_i;
      sync2 <= sync1;
      hist  <= sync2;
    end
  end

  // The active prescale value only changes at a tick, so mid-count writes wait their turn.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pcnt    <= '0;
      psc_act <= '0;
    end else begin
      pcnt <= (rise || tick) ? '0 : pcnt + CNT_W'(1);
      if (tick) psc_act <= prescale;
    end
  end

`ifdef PWM_CAPTURE_TIMEOUT_EN
  logic [CNT_W-1:0] timeout_q, to_cnt;
  logic             to_active;

  assign to_active = (timeout_q != '0) && (counting || (state == ARM));
  assign to_evt    = to_active && !rise && !fall && tick &&
                     ((to_cnt + CNT_W'(1)) == timeout_q) && !dis_wr;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      to_cnt    <= '0;
      timeout_q <= '0;
      tmo_flag  <= 1'b0;
    end else begin
      if (write && (addr_i == 8'h14)) timeout_q <= wdata_i[CNT_W-1:0];
      tmo_flag <= to_evt || (tmo_flag && !(wr_stat && wdata_i[2]));
      if (!to_active || rise || fall || to_evt) to_cnt <= '0;
      else if (tick)                           to_cnt <= to_cnt + CNT_W'(1);
    end
  end
`else
  assign to_evt   = 1'b0;
  assign tmo_flag = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= IDLE;
      cnt      <= '0;
      shadow   <= '0;
      high_q   <= '0;
      period_q <= '0;
    end else if (dis_wr) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (to_evt) begin
      state <= ARM;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (ctrl_en) state <= ARM;
        end
        ARM: begin
          if (rise) begin
            state <= HIGH_PH;
            cnt   <= '0;
          end
        end
        HIGH_PH: begin
          cnt <= cnt_inc;
          if (fall) begin
            shadow <= cnt_inc;
            state  <= LOW_PH;
          end
        end
        LOW_PH: begin
          if (rise) begin
            high_q   <= shadow;
            period_q <= cnt_inc;
            cnt      <= '0;
            state    <= ctrl_os ? DONE : HIGH_PH;
          end else begin
            cnt <= cnt_inc;
          end
        end
        DONE: begin
          if (!valid) state <= ARM;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Status bits are write-one-to-clear; a same-cycle set event wins.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ctrl_en  <= 1'b0;
      ctrl_irq <= 1'b0;
      ctrl_os  <= 1'b0;
      prescale <= '0;
      valid    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        ctrl_en  <= wdata_i[0];
        ctrl_irq <= wdata_i[1];
        ctrl_os  <= wdata_i[2];
      end
      if (wr_psc) prescale <= wdata_i[CNT_W-1:0];
      valid    <= cap_evt || (valid && !(wr_stat && wdata_i[0]));
      overflow <= ovf_evt || (overflow && !(wr_stat && wdata_i[1]));
    end
  end

  always_comb begin
    rdata_o = '0;
    case (addr_i)
      8'h00: rdata_o[2:0]       = {ctrl_os, ctrl_irq, ctrl_en};
      8'h04: rdata_o[CNT_W-1:0] = prescale;
      8'h08: rdata_o[CNT_W-1:0] = high_q;
      8'h0C: rdata_o[CNT_W-1:0] = period_q;
      8'h10: rdata_o[2:0]       = {tmo_flag, overflow, valid};
`ifdef PWM_CAPTURE_TIMEOUT_EN
      8'h14: rdata_o[CNT_W-1:0] = timeout_q;
`endif
      default: rdata_o = '0;
    endcase
  end

  assign irq_o = ctrl_irq && (valid || tmo_flag);

endmodule

// File: tb/tb_pwm_capture.sv
// Self-checking bench for pwm_capture: vector table, random trials against a
// tick-count model, and hand-written corner sequences.
module tb_pwm_capture;

  localparam int CNT_W = 16;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        write;
  logic [7:0]  addr_i;
  logic [31:0] wdata_i;
  logic [31:0] rdata_o;
  logic        pwm_i;
  logic        irq_o;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int p;
    int th;
    int tl;
    int exp_high;
    int exp_period;
  } vec_t;

  vec_t vecs[5];

  pwm_capture #(.CNT_W(CNT_W)) dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .write   (write),
    .addr_i  (addr_i),
    .wdata_i (wdata_i),
    .rdata_o (rdata_o),
    .pwm_i   (pwm_i),
    .irq_o   (irq_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic drive(input logic level, input int n);
    repeat (n) begin
      @(negedge clk_i);
      pwm_i = level;
    end
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk_i);
    write   = 1'b1;
    addr_i  = a;
    wdata_i = d;
    @(negedge clk_i);
    write   = 1'b0;
    wdata_i = '0;
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [31:0] d);
    @(negedge clk_i);
    addr_i = a;
    #1;
    d = rdata_o;
  endtask

  // n full high/low periods, then a final rising edge held long enough to be detected.
  task automatic apply_stimulus(input int th, input int tl, input int n);
    repeat (n) begin
      drive(1'b1, th);
      drive(1'b0, tl);
    end
    drive(1'b1, 6);
  endtask

  // Ticks come every p+1 cycles after a rising edge; the count saturates at all-ones.
  function automatic int model_count(input int cycles, input int p);
    int c;
    c = cycles / (p + 1);
    return (c > (1 << CNT_W) - 1) ? (1 << CNT_W) - 1 : c;
  endfunction

  task automatic run_capture(input string name, input int p, input int th, input int tl,
                             input int eh, input int ep);
    logic [31:0] d;
    bus_write(8'h00, 32'h0);
    drive(1'b0, 4);
    bus_write(8'h04, p);
    drive(1'b0, 10);
    bus_write(8'h00, 32'h1);
    drive(1'b0, 5);
    apply_stimulus(th, tl, 3);
    bus_read(8'h08, d);
    check_output($sformatf("%s HIGH", name), d, eh);
    bus_read(8'h0C, d);
    check_output($sformatf("%s PERIOD", name), d, ep);
    bus_read(8'h10, d);
    check_output($sformatf("%s valid", name), {31'b0, d[0]}, 32'h1);
    check_output($sformatf("%s irq masked", name), {31'b0, irq_o}, 32'h0);
  endtask

  initial begin
    logic [31:0] d;
    int p, th, tl;

    vecs[0] = '{p: 0, th: 10, tl: 30, exp_high: 10, exp_period: 40};
    vecs[1] = '{p: 1, th: 10, tl: 30, exp_high: 5,  exp_period: 20};
    vecs[2] = '{p: 2, th: 7,  tl: 5,  exp_high: 2,  exp_period: 4};
    vecs[3] = '{p: 3, th: 8,  tl: 8,  exp_high: 2,  exp_period: 4};
    vecs[4] = '{p: 0, th: 2,  tl: 2,  exp_high: 2,  exp_period: 4};

    rst_ni  = 1'b0;
    write   = 1'b0;
    addr_i  = '0;
    wdata_i = '0;
    pwm_i   = 1'b0;

    #2;
    check_output("reset irq", {31'b0, irq_o}, 32'h0);
    for (int i = 0; i < 5; i++) begin
      bus_read(8'(i * 4), d);
      check_output($sformatf("reset reg 0x%0h", i * 4), d, 32'h0);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;

    bus_read(8'h18, d);
    check_output("unmapped read", d, 32'h0);

    for (int i = 0; i < 5; i++)
      run_capture($sformatf("vec%0d", i), vecs[i].p, vecs[i].th, vecs[i].tl,
                  vecs[i].exp_high, vecs[i].exp_period);

    for (int i = 0; i < 6; i++) begin
      p  = int'($urandom_range(0, 3));
      th = int'($urandom_range(2, 30));
      tl = int'($urandom_range(2, 30));
      run_capture($sformatf("rand%0d p=%0d th=%0d tl=%0d", i, p, th, tl), p, th, tl,
                  model_count(th, p), model_count(th + tl, p));
    end

    // Interrupt follows valid, clears on write-one, returns on the next capture.
    bus_write(8'h00, 32'h0);
    bus_write(8'h04, 32'h1);
    drive(1'b0, 10);
    bus_write(8'h00, 32'h3);
    drive(1'b0, 5);
    apply_stimulus(10, 30, 3);
    check_output("irq set", {31'b0, irq_o}, 32'h1);
    bus_write(8'h10, 32'h1);
    check_output("irq cleared", {31'b0, irq_o}, 32'h0);
    bus_read(8'h10, d);
    check_output("valid cleared", {31'b0, d[0]}, 32'h0);
    drive(1'b0, 30);
    drive(1'b1, 6);
    check_output("irq reasserted", {31'b0, irq_o}, 32'h1);

    // One-shot: first capture sticks until valid is cleared.
    bus_write(8'h00, 32'h0);
    bus_write(8'h04, 32'h0);
    drive(1'b0, 10);
    bus_write(8'h00, 32'h5);
    drive(1'b0, 5);
    apply_stimulus(10, 30, 3);
    apply_stimulus(5, 15, 3);
    bus_read(8'h08, d);
    check_output("oneshot HIGH held", d, 32'd10);
    bus_read(8'h0C, d);
    check_output("oneshot PERIOD held", d, 32'd40);
    bus_write(8'h10, 32'h1);
    drive(1'b0, 5);
    apply_stimulus(5, 15, 3);
    bus_read(8'h08, d);
    check_output("oneshot rearm HIGH", d, model_count(5, 0));
    bus_read(8'h0C, d);
    check_output("oneshot rearm PERIOD", d, model_count(20, 0));

    // Saturation of a very long high phase.
    bus_write(8'h00, 32'h0);
    bus_write(8'h04, 32'h0);
    drive(1'b0, 6);
    bus_write(8'h00, 32'h1);
    drive(1'b0, 5);
    drive(1'b1, 70000);
    drive(1'b0, 10);
    drive(1'b1, 6);
    bus_read(8'h08, d);
    check_output("overflow HIGH", d, model_count(70000, 0));
    bus_read(8'h0C, d);
    check_output("overflow PERIOD", d, model_count(70010, 0));
    bus_read(8'h10, d);
    check_output("overflow flag", {31'b0, d[1]}, 32'h1);
    bus_write(8'h10, 32'h2);
    bus_read(8'h10, d);
    check_output("overflow cleared", {31'b0, d[1]}, 32'h0);

    // Asynchronous reset in the middle of a high phase.
    bus_write(8'h00, 32'h0);
    drive(1'b0, 10);
    bus_write(8'h00, 32'h3);
    drive(1'b0, 5);
    apply_stimulus(10, 30, 2);
    check_output("pre-reset irq", {31'b0, irq_o}, 32'h1);
    bus_read(8'h08, d);
    check_output("pre-reset HIGH", d, 32'd10);
    @(negedge clk_i);
    #2;
    rst_ni = 1'b0;
    #1;
    check_output("async reset irq", {31'b0, irq_o}, 32'h0);
    check_output("async reset rdata", rdata_o, 32'h0);
    bus_read(8'h00, d);
    check_output("in-reset CTRL", d, 32'h0);
    bus_read(8'h10, d);
    check_output("in-reset STATUS", d, 32'h0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    drive(1'b0, 5);
    apply_stimulus(10, 30, 3);
    bus_read(8'h08, d);
    check_output("post-reset no capture HIGH", d, 32'h0);
    bus_read(8'h10, d);
    check_output("post-reset no capture STATUS", d, 32'h0);
    bus_write(8'h00, 32'h1);
    drive(1'b0, 5);
    apply_stimulus(10, 30, 3);
    bus_read(8'h08, d);
    check_output("post-reset capture HIGH", d, 32'd10);
    bus_read(8'h0C, d);
    check_output("post-reset capture PERIOD", d, 32'd40);

`ifdef PWM_CAPTURE_TIMEOUT_EN
    bus_write(8'h00, 32'h0);
    bus_write(8'h04, 32'h0);
    bus_write(8'h14, 32'd100);
    drive(1'b0, 10);
    bus_write(8'h00, 32'h1);
    drive(1'b0, 50);
    bus_read(8'h10, d);
    check_output("timeout not yet", {31'b0, d[2]}, 32'h0);
    drive(1'b0, 60);
    bus_read(8'h10, d);
    check_output("timeout set", {31'b0, d[2]}, 32'h1);
    bus_read(8'h14, d);
    check_output("timeout reg", d, 32'd100);
    apply_stimulus(10, 30, 3);
    bus_read(8'h08, d);
    check_output("timeout rearm HIGH", d, 32'd10);
`else
    bus_read(8'h14, d);
    check_output("timeout reg absent", d, 32'h0);
    bus_write(8'h00, 32'h0);
    drive(1'b0, 200);
    bus_read(8'h10, d);
    check_output("timeout bit held low", {31'b0, d[2]}, 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
